// File: rtl/data_bus_pkg.sv
`default_nettype none
// ============================================================================
// data_bus_pkg : data-bus mode/width/state encodings and access helpers
// Revision 1.0
// ============================================================================
package data_bus_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_READ  = 2'b01,
      MODE_WRITE = 2'b10,
      MODE_RSVD  = 2'b11
   } bus_mode_e;

   typedef enum logic [1:0] {
      WIDTH_BYTE    = 2'b00,
      WIDTH_HALF    = 2'b01,
      WIDTH_WORD    = 2'b10,
      WIDTH_ILLEGAL = 2'b11
   } bus_width_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_MERGE = 2'd2,
      ST_ACK   = 2'd3
   } resp_state_e;

   // Misaligned half/word accesses and the illegal width abort the transaction.
   function automatic logic access_bad(input bus_width_e width, input logic [1:0] offset);
      case (width)
         WIDTH_BYTE: access_bad = 1'b0;
         WIDTH_HALF: access_bad = offset[0];
         WIDTH_WORD: access_bad = (offset != 2'b00);
         default:    access_bad = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input bus_width_e width, input logic [1:0] offset);
      case (width)
         WIDTH_BYTE: lane_mask = 4'b0001 << offset;
         WIDTH_HALF: lane_mask = 4'b0011 << offset;
         default:    lane_mask = 4'b1111;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_bus_ram_responder_if.sv
`default_nettype none
// ============================================================================
// data_bus_ram_responder_if : request/handshake side of the data bus
// Revision 1.0
// ============================================================================
interface data_bus_ram_responder_if;

   logic [31:0] addr;
   logic [1:0]  mode;
   logic [1:0]  reqw;
   logic        reqs;
   logic        ready;
   logic        error;

   modport master (output addr, mode, reqw, reqs, input ready, error);
   modport slave  (input addr, mode, reqw, reqs, output ready, error);

endinterface
`default_nettype wire

// File: rtl/data_bus_ram_responder_load_extender.sv
`default_nettype none
// ============================================================================
// load_extender : selects the addressed lanes of a word and sign/zero extends
// Revision 1.0
// ============================================================================
module load_extender
   import data_bus_pkg::*;
(
   input  wire [31:0]       word,
   input  wire [1:0]        offset,
   input  wire bus_width_e  width,
   input  wire              is_signed,
   output logic [31:0]      result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = word >> {offset, 3'b000};
      case (width)
         WIDTH_BYTE: result = {{24{is_signed & shifted[7]}}, shifted[7:0]};
         WIDTH_HALF: result = {{16{is_signed & shifted[15]}}, shifted[15:0]};
         default:    result = word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/data_bus_ram_responder.sv
`default_nettype none
// ============================================================================
// data_bus_ram_responder : local word RAM answering byte/half/word data-bus requests
// Revision 1.0
// ============================================================================
module data_bus_ram_responder
   import data_bus_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0001_0000
)(
   input  wire                      clk,
   input  wire                      reset_n,
   data_bus_ram_responder_if.slave  bus,
   inout  wire [31:0]               data_bus_data
);

   localparam int unsigned IDX_BITS = ADDR_BITS - 2;
   localparam int unsigned WORDS    = 1 << IDX_BITS;

   logic [31:0]          mem [WORDS];
   logic [31:0]          ram_q;

   resp_state_e          state_q, state_d;
   bus_mode_e            mode_q, mode_d;
   bus_width_e           width_q, width_d;
   logic                 sign_q, sign_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 ready_q, ready_d;
   logic                 error_q, error_d;
   logic                 drive_q, drive_d;

   bus_mode_e            bus_mode;
   bus_width_e           bus_width;
   logic                 selected;
   logic                 req_valid;
   logic [IDX_BITS-1:0]  rd_idx;
   logic                 mem_we;
   logic [IDX_BITS-1:0]  mem_widx;
   logic [31:0]          mem_wdata;
   logic [31:0]          ext_result;
   logic [31:0]          wshift;
   logic [31:0]          merged;
   logic [3:0]           mask;

   assign bus_mode  = bus_mode_e'(bus.mode);
   assign bus_width = bus_width_e'(bus.reqw);
   assign selected  = (bus.addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
   assign req_valid = selected && ((bus_mode == MODE_READ) || (bus_mode == MODE_WRITE));

   // While idle the RAM is read at the incoming address so the word is ready in READ.
   assign rd_idx = (state_q == ST_IDLE) ? bus.addr[ADDR_BITS-1:2] : addr_q[ADDR_BITS-1:2];

   always_ff @(posedge clk) begin
      if (mem_we && reset_n) begin
         mem[mem_widx] <= mem_wdata;
      end
      ram_q <= mem[rd_idx];
   end

   load_extender u_load_extender (
      .word      (ram_q),
      .offset    (addr_q[1:0]),
      .width     (width_q),
      .is_signed (sign_q),
      .result    (ext_result)
   );

   always_comb begin
      mask   = lane_mask(width_q, addr_q[1:0]);
      wshift = wdata_q << {addr_q[1:0], 3'b000};
      merged = ram_q;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            merged[i*8 +: 8] = wshift[i*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      width_d   = width_q;
      sign_d    = sign_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      ready_d   = ready_q;
      error_d   = error_q;
      drive_d   = drive_q;
      mem_we    = 1'b0;
      mem_widx  = addr_q[ADDR_BITS-1:2];
      mem_wdata = merged;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               mode_d  = bus_mode;
               width_d = bus_width;
               sign_d  = bus.reqs;
               addr_d  = bus.addr[ADDR_BITS-1:0];
               wdata_d = data_bus_data;
               rdata_d = 32'h0;
               if (access_bad(bus_width, bus.addr[1:0])) begin
                  state_d = ST_ACK;
                  ready_d = 1'b1;
                  error_d = 1'b1;
                  drive_d = (bus_mode == MODE_READ);
               end else if ((bus_mode == MODE_READ) || (bus_width != WIDTH_WORD)) begin
                  state_d = ST_READ;
               end else begin
                  // Full-word writes need no merge and commit on the sampling edge.
                  mem_we    = 1'b1;
                  mem_widx  = bus.addr[ADDR_BITS-1:2];
                  mem_wdata = data_bus_data;
                  state_d   = ST_ACK;
                  ready_d   = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (mode_q == MODE_READ) begin
               rdata_d = ext_result;
               state_d = ST_ACK;
               ready_d = 1'b1;
               drive_d = 1'b1;
            end else begin
               state_d = ST_MERGE;
            end
         end
         ST_MERGE: begin
            mem_we  = 1'b1;
            state_d = ST_ACK;
            ready_d = 1'b1;
         end
         ST_ACK: begin
            if (bus_mode == MODE_IDLE) begin
               state_d = ST_IDLE;
               ready_d = 1'b0;
               error_d = 1'b0;
               drive_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_IDLE;
         width_q <= WIDTH_BYTE;
         sign_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         drive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         width_q <= width_d;
         sign_q  <= sign_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         error_q <= error_d;
         drive_q <= drive_d;
      end
   end

   assign bus.ready     = ready_q;
   assign bus.error     = error_q;
   assign data_bus_data = drive_q ? rdata_q : 32'bz;

endmodule
`default_nettype wire

// File: doc/data_bus_ram_responder.md
DATA_BUS_RAM_RESPONDER -- requirements
Module: data_bus_ram_responder

Interface
REQ-001 Parameter ADDR_BITS, default 12, SHALL set the byte-address width of the local RAM (2^(ADDR_BITS-2) 32-bit words).
REQ-002 Parameter BASE_ADDR, default 32'h0001_0000, SHALL set the region base; it is aligned to 2^ADDR_BITS.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Port reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port data_bus_addr  input  32  SHALL carry the byte address.
REQ-006 Port data_bus_mode  input  2  SHALL carry the request: 00 idle, 01 read, 10 write, 11 reserved (treated as idle).
REQ-007 Port data_bus_reqw  input  2  SHALL carry the width: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 Port data_bus_reqs  input  1  SHALL select sign extension (1) or zero extension (0) for sub-word reads.
REQ-009 Port data_bus_data  inout  32  SHALL carry write data from the initiator and read data from this block.
REQ-010 Port data_bus_ready  output  1  SHALL signal transaction completion.
REQ-011 Port data_bus_error  output  1  SHALL flag an aborted (misaligned or illegal-width) transaction; valid only while data_bus_ready=1.

Function
REQ-012 The block SHALL be selected when data_bus_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]; unselected requests SHALL be ignored, with no state change.
REQ-013 FSM states SHALL be IDLE, READ, MERGE and ACK.
REQ-014 In IDLE with a selected mode 01/10, the block SHALL latch addr, reqw, reqs, mode and write data; later input changes SHALL NOT affect the transaction.
REQ-015 Misalignment SHALL be a half access with addr[0]=1 or a word access with addr[1:0]!=00; misalignment or reqw=11 SHALL cause IDLE->ACK with error=1, no RAM write, and read data 0.
REQ-016 A read SHALL go IDLE->READ (RAM word fetched)->ACK, so ready rises 2 cycles after the request is sampled.
REQ-017 A word write SHALL write the RAM on the sampling edge and go IDLE->ACK, so ready rises 1 cycle after sampling.
REQ-018 A byte/half write SHALL go IDLE->READ->MERGE, replace only the addressed lanes (little-endian, lane = addr[1:0]), write the word in MERGE, then go to ACK.
REQ-019 Read data SHALL select lanes by addr[1:0]; byte/half results SHALL be sign-extended when reqs=1 and zero-extended otherwise; word reads SHALL be returned unmodified.
REQ-020 In ACK the block SHALL hold ready=1, hold error, and drive data_bus_data with the registered read result when the latched mode is read.
REQ-021 In all other cases data_bus_data SHALL be 32'bz.
REQ-022 ACK SHALL persist until data_bus_mode==00, then go to IDLE; a held request SHALL never be re-executed.
REQ-023 A new request SHALL be accepted no earlier than the cycle after the return to IDLE (minimum one idle cycle between transactions).
REQ-024 data_bus_ready and data_bus_error SHALL be registered outputs (no combinational input-to-output path).

Reset
REQ-025 reset_n=0 SHALL immediately force state=IDLE, ready=0, error=0, the read register to 0 and data_bus_data to z.
REQ-026 Reset during READ/MERGE SHALL abort the transaction with no RAM write; a write committed on an earlier edge SHALL remain.
REQ-027 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-028 Mode encodings, width encodings and FSM state encodings SHALL live in the shared package data_bus_pkg, which the initiator-side unit also uses.
REQ-029 Lane selection and extension SHALL be one combinational sub-module, load_extender (inputs word, offset, width, signed; output 32-bit result).
REQ-030 The RAM SHALL be an inferred synchronous-read word array inside this module.

Verification
REQ-031 Word write 32'hDEADBEEF to 0x10004, then word read 0x10004 -> ready after 1 and 2 cycles respectively; read data 32'hDEADBEEF; error=0.
REQ-032 After REQ-031, byte read 0x10007 with reqs=1 -> 32'hFFFFFFDE; with reqs=0 -> 32'h000000DE; half read 0x10004 with reqs=1 -> 32'hFFFFBEEF.
REQ-033 Byte write 8'h55 to 0x10005, then word read 0x10004 -> 32'hDEAD55EF; ready after 3 cycles for the write.
REQ-034 Half read 0x10001 and word write 0x10002 -> ready with error=1, read data 0, RAM word at 0x10000 unchanged.
REQ-035 Request to 0x20000 -> ready stays 0 and data_bus_data stays z indefinitely; mode held high in ACK for 5 cycles -> single RAM write, ready held 5 cycles.
REQ-036 reset_n pulsed low during MERGE of a byte write to 0x10008 -> immediate IDLE, ready=0, target word unchanged.
